// File: rtl/spi_flash_responder.sv
// Serial-NOR flash responder on a synchronized SPI mode-0 link, backed by an on-chip byte RAM.
// Supports JEDEC ID, RDSR, WREN/WRDI, READ, page program (AND semantics) and chip erase.
module spi_flash_responder #(
  parameter int unsigned MEM_BYTES   = 4096,
  parameter logic [23:0] JEDEC_ID    = 24'hEF4016,
  parameter int unsigned PROG_CYCLES = 64
) (
  input  logic CLK,
  input  logic RESET,
  input  logic SPI_CLK,
  input  logic SPI_SS_N,
  input  logic SPI_MOSI,
  output logic SPI_MISO,
  output logic BUSY,
  output logic WEL
);
  localparam int unsigned AW = $clog2(MEM_BYTES);
  localparam int unsigned PW = (PROG_CYCLES > 1) ? $clog2(PROG_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_RD_DATA, S_WR_DATA, S_ID_OUT, S_STAT_OUT, S_IGNORE
  } state_e;
  typedef enum logic [1:0] {P_NONE, P_WREN, P_WRDI, P_CE} pend_e;

  state_e          state_q, state_d;
  pend_e           pend_q, pend_d;
  logic [2:0]      sclk_sync_q, sclk_sync_d;
  logic [2:0]      ss_sync_q, ss_sync_d;
  logic [1:0]      mosi_sync_q, mosi_sync_d;
  logic [6:0]      rx_q, rx_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [7:0]      tx_q, tx_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            op_wr_q, op_wr_d;
  logic            programmed_q, programmed_d;
  logic            fetch_q, fetch_d;
  logic            load_q, load_d;
  logic            miso_q, miso_d;
  logic            busy_q, busy_d;
  logic            wel_q, wel_d;
  logic            erase_q, erase_d;
  logic [AW-1:0]   erase_cnt_q, erase_cnt_d;
  logic            prog_q, prog_d;
  logic [PW-1:0]   prog_cnt_q, prog_cnt_d;

  logic            sclk_rise_c, sclk_fall_c, ss_fall_c, ss_rise_c, byte_done_c;
  logic [7:0]      rx_byte_c, status_c;
  logic            fetch_req_c;
  logic            mem_we_c, mem_re_c;
  logic [AW-1:0]   mem_addr_c;
  logic [7:0]      mem_wdata_c;
  logic [7:0]      mem [MEM_BYTES];
  logic [7:0]      ram_dout;

  assign sclk_rise_c = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall_c = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign ss_fall_c   = ~ss_sync_q[1] & ss_sync_q[2];
  assign ss_rise_c   = ss_sync_q[1] & ~ss_sync_q[2];
  assign byte_done_c = sclk_rise_c && (bit_cnt_q == 3'd7);
  assign rx_byte_c   = {rx_q, mosi_sync_q[1]};
  assign status_c    = {6'b0, wel_q, busy_q};

  assign SPI_MISO = miso_q;
  assign BUSY     = busy_q;
  assign WEL      = wel_q;

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    sclk_sync_d  = {sclk_sync_q[1:0], SPI_CLK};
    ss_sync_d    = {ss_sync_q[1:0], SPI_SS_N};
    mosi_sync_d  = {mosi_sync_q[0], SPI_MOSI};
    rx_d         = rx_q;
    bit_cnt_d    = bit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    tx_d         = tx_q;
    addr_d       = addr_q;
    op_wr_d      = op_wr_q;
    programmed_d = programmed_q;
    load_d       = 1'b0;
    miso_d       = miso_q;
    busy_d       = busy_q;
    wel_d        = wel_q;
    erase_d      = erase_q;
    erase_cnt_d  = erase_cnt_q;
    prog_d       = prog_q;
    prog_cnt_d   = prog_cnt_q;
    fetch_req_c  = 1'b0;
    mem_we_c     = 1'b0;
    mem_re_c     = 1'b0;
    mem_addr_c   = addr_q;
    mem_wdata_c  = 8'hFF;

    // Background chip eraser owns the RAM port while active
    if (erase_q) begin
      mem_we_c    = 1'b1;
      mem_addr_c  = erase_cnt_q;
      erase_cnt_d = erase_cnt_q + AW'(1);
      if (erase_cnt_q == AW'(MEM_BYTES - 1)) begin
        erase_d = 1'b0;
        busy_d  = 1'b0;
        wel_d   = 1'b0;
      end
    end
    if (prog_q) begin
      if (prog_cnt_q == '0) begin
        prog_d = 1'b0;
        busy_d = 1'b0;
      end else begin
        prog_cnt_d = prog_cnt_q - PW'(1);
      end
    end
    if (load_q) tx_d = ram_dout;

    if (sclk_rise_c) begin
      rx_d      = rx_byte_c[6:0];
      bit_cnt_d = bit_cnt_q + 3'd1;
      pend_d    = P_NONE;
    end
    if (sclk_fall_c) begin
      miso_d = tx_q[7];
      tx_d   = {tx_q[6:0], 1'b0};
    end

    case (state_q)
      S_IDLE: begin
        miso_d = 1'b0;
        if (ss_fall_c) begin
          state_d      = S_CMD;
          bit_cnt_d    = 3'd0;
          tx_d         = 8'h00;
          programmed_d = 1'b0;
          pend_d       = P_NONE;
        end
      end
      S_CMD: if (byte_done_c) begin
        byte_cnt_d = 2'd0;
        state_d    = S_IGNORE;
        if (!busy_q || rx_byte_c == 8'h05) begin
          case (rx_byte_c)
            8'h9F: begin state_d = S_ID_OUT; tx_d = JEDEC_ID[23:16]; byte_cnt_d = 2'd1; end
            8'h05: begin state_d = S_STAT_OUT; tx_d = status_c; end
            8'h06: pend_d = P_WREN;
            8'h04: pend_d = P_WRDI;
            8'hC7: pend_d = P_CE;
            8'h03: begin state_d = S_ADDR; op_wr_d = 1'b0; end
            8'h02: if (wel_q) begin state_d = S_ADDR; op_wr_d = 1'b1; end
            default: state_d = S_IGNORE;
          endcase
        end
      end
      S_ADDR: if (byte_done_c) begin
        addr_d     = AW'({addr_q, rx_byte_c});
        byte_cnt_d = byte_cnt_q + 2'd1;
        if (byte_cnt_q == 2'd2) begin
          state_d     = op_wr_q ? S_WR_DATA : S_RD_DATA;
          fetch_req_c = 1'b1;
        end
      end
      S_RD_DATA: if (byte_done_c) begin
        addr_d      = addr_q + AW'(1);
        fetch_req_c = 1'b1;
      end
      // Program clears bits only; the address wraps inside the 256-byte page
      S_WR_DATA: if (byte_done_c && !erase_q) begin
        mem_we_c     = 1'b1;
        mem_addr_c   = addr_q;
        mem_wdata_c  = ram_dout & rx_byte_c;
        addr_d       = (addr_q & ~AW'(8'hFF)) | AW'(8'(addr_q[7:0] + 8'd1));
        fetch_req_c  = 1'b1;
        programmed_d = 1'b1;
      end
      S_ID_OUT: if (byte_done_c) begin
        case (byte_cnt_q)
          2'd1:    tx_d = JEDEC_ID[15:8];
          2'd2:    tx_d = JEDEC_ID[7:0];
          default: tx_d = 8'h00;
        endcase
        if (byte_cnt_q != 2'd3) byte_cnt_d = byte_cnt_q + 2'd1;
      end
      S_STAT_OUT: if (byte_done_c) tx_d = status_c;
      S_IGNORE: miso_d = 1'b0;
      default: state_d = S_IDLE;
    endcase

    if (ss_rise_c && state_q != S_IDLE) begin
      state_d     = S_IDLE;
      miso_d      = 1'b0;
      tx_d        = 8'h00;
      fetch_req_c = 1'b0;
      case (pend_q)
        P_WREN: wel_d = 1'b1;
        P_WRDI: wel_d = 1'b0;
        P_CE: if (wel_q) begin
          erase_d     = 1'b1;
          erase_cnt_d = '0;
          busy_d      = 1'b1;
        end
        default: ;
      endcase
      if (state_q == S_WR_DATA && programmed_q) begin
        wel_d      = 1'b0;
        busy_d     = 1'b1;
        prog_d     = 1'b1;
        prog_cnt_d = PW'(PROG_CYCLES - 1);
      end
    end

    // Read fetch takes the port only when no write needs it; otherwise it retries
    if (fetch_q && !mem_we_c) begin
      mem_re_c = 1'b1;
      load_d   = (state_q == S_RD_DATA);
    end
    fetch_d = fetch_req_c | (fetch_q & mem_we_c);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      pend_q       <= P_NONE;
      sclk_sync_q  <= 3'b000;
      ss_sync_q    <= 3'b000;
      mosi_sync_q  <= 2'b00;
      rx_q         <= '0;
      bit_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      tx_q         <= '0;
      addr_q       <= '0;
      op_wr_q      <= 1'b0;
      programmed_q <= 1'b0;
      fetch_q      <= 1'b0;
      load_q       <= 1'b0;
      miso_q       <= 1'b0;
      busy_q       <= 1'b0;
      wel_q        <= 1'b0;
      erase_q      <= 1'b0;
      erase_cnt_q  <= '0;
      prog_q       <= 1'b0;
      prog_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      sclk_sync_q  <= sclk_sync_d;
      ss_sync_q    <= ss_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      rx_q         <= rx_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      tx_q         <= tx_d;
      addr_q       <= addr_d;
      op_wr_q      <= op_wr_d;
      programmed_q <= programmed_d;
      fetch_q      <= fetch_d;
      load_q       <= load_d;
      miso_q       <= miso_d;
      busy_q       <= busy_d;
      wel_q        <= wel_d;
      erase_q      <= erase_d;
      erase_cnt_q  <= erase_cnt_d;
      prog_q       <= prog_d;
      prog_cnt_q   <= prog_cnt_d;
    end
  end

  // Single-port RAM, contents deliberately not reset
  always_ff @(posedge CLK) begin
    if (mem_we_c) mem[mem_addr_c] <= mem_wdata_c;
    if (mem_re_c) ram_dout <= mem[mem_addr_c];
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: an SPI mode-0 master drives commands and a
// scoreboard monitor pairs each captured response with its queued expectation.
module tb_spi_flash_responder;
  localparam int HALF = 8;

  logic clk, rst, sclk, ss_n, mosi;
  logic miso, busy, wel;

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  string       name_q[$];
  int          checks, errors;

  spi_flash_responder dut (
    .CLK(clk), .RESET(rst), .SPI_CLK(sclk), .SPI_SS_N(ss_n), .SPI_MOSI(mosi),
    .SPI_MISO(miso), .BUSY(busy), .WEL(wel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    name_q.push_back(name);
    exp_q.push_back(exp);
    got_q.push_back(got);
  endtask

  task automatic spi_begin();
    ss_n = 1'b0;
    idle(HALF);
  endtask

  task automatic spi_end();
    idle(HALF);
    ss_n = 1'b1;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic [7:0] r = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      idle(HALF);
      r = {r[6:0], miso};
      sclk = 1'b1;
      idle(HALF);
      sclk = 1'b0;
    end
    rx = r;
  endtask

  task automatic send(input logic [7:0] b);
    logic [7:0] unused_rx;
    spi_byte(b, unused_rx);
  endtask

  task automatic rd_byte(input string name, input logic [7:0] exp);
    logic [7:0] r;
    name_q.push_back(name);
    exp_q.push_back({24'h0, exp});
    spi_byte(8'h00, r);
    got_q.push_back({24'h0, r});
  endtask

  task automatic cmd1(input logic [7:0] op);
    spi_begin();
    send(op);
    spi_end();
    idle(2 * HALF);
  endtask

  task automatic cmd_addr(input logic [7:0] op, input logic [23:0] a);
    send(op);
    send(a[23:16]);
    send(a[15:8]);
    send(a[7:0]);
  endtask

  task automatic measure_busy(output int n);
    int t = 0;
    n = 0;
    while (!busy && t < 50) begin @(negedge clk); t++; end
    while (busy && n < 20000) begin @(negedge clk); n++; end
  endtask

  initial begin
    int n;
    logic [7:0] r;
    checks = 0;
    errors = 0;
    rst = 1'b1; sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0;

    // Scoreboard monitor: compares each presented result with the oldest expectation
    fork
      forever begin
        @(negedge clk);
        while (got_q.size() > 0) begin
          logic [31:0] g;
          g = got_q.pop_front();
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result: got %0h with no expectation queued", g);
          end else begin
            logic [31:0] e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (g !== e) begin
              errors++;
              $display("FAIL %s: got %0h expected %0h", nm, g, e);
            end
          end
        end
      end
    join_none

    idle(5);
    rst = 1'b0;
    idle(5);
    chk("reset_miso", {31'h0, miso}, 0);
    chk("reset_busy", {31'h0, busy}, 0);
    chk("reset_wel", {31'h0, wel}, 0);

    spi_begin(); send(8'h9F);
    rd_byte("id0", 8'hEF); rd_byte("id1", 8'h40); rd_byte("id2", 8'h16); rd_byte("id3", 8'h00);
    spi_end(); idle(2 * HALF);

    cmd1(8'h06);
    spi_begin(); send(8'h05); rd_byte("rdsr_wel", 8'h02); spi_end(); idle(2 * HALF);
    chk("wel_set", {31'h0, wel}, 1);

    spi_begin(); send(8'hC7); spi_end();
    fork
      measure_busy(n);
      begin
        idle(10);
        spi_begin(); send(8'h05); rd_byte("rdsr_erasing", 8'h03); spi_end();
      end
    join
    chk("erase_busy_cycles", n, 4096);
    chk("wel_after_erase", {31'h0, wel}, 0);
    idle(2 * HALF);
    spi_begin(); send(8'h05); rd_byte("rdsr_after_erase", 8'h00); spi_end(); idle(2 * HALF);

    spi_begin(); cmd_addr(8'h03, 24'h000000);
    for (int i = 0; i < 4; i++) rd_byte("erased_rd", 8'hFF);
    spi_end(); idle(2 * HALF);
    spi_begin(); cmd_addr(8'h03, 24'h000FFF);
    rd_byte("rd_fff", 8'hFF); rd_byte("rd_wrap0", 8'hFF);
    spi_end(); idle(2 * HALF);

    cmd1(8'h06);
    spi_begin(); cmd_addr(8'h02, 24'h0000FE);
    send(8'hAA); send(8'h55); send(8'h33);
    spi_end();
    measure_busy(n);
    chk("prog_busy_cycles", n, 64);
    chk("wel_after_prog", {31'h0, wel}, 0);
    idle(2 * HALF);

    spi_begin(); cmd_addr(8'h03, 24'h0000FE);
    rd_byte("rd_fe", 8'hAA); rd_byte("rd_ff", 8'h55); rd_byte("rd_100", 8'hFF);
    spi_end(); idle(2 * HALF);
    spi_begin(); cmd_addr(8'h03, 24'h000000); rd_byte("rd_page_wrap", 8'h33); spi_end(); idle(2 * HALF);

    spi_begin(); cmd_addr(8'h02, 24'h000010); send(8'h0F); spi_end();
    idle(10);
    chk("busy_no_wren", {31'h0, busy}, 0);
    idle(2 * HALF);
    spi_begin(); cmd_addr(8'h03, 24'h000010); rd_byte("rd_10_unchanged", 8'hFF); spi_end(); idle(2 * HALF);

    cmd1(8'h06);
    spi_begin(); cmd_addr(8'h02, 24'h0000FE); send(8'h0F); spi_end();
    measure_busy(n);
    chk("prog2_busy_cycles", n, 64);
    idle(2 * HALF);
    spi_begin(); cmd_addr(8'h03, 24'h0000FE); rd_byte("rd_and", 8'h0A); spi_end(); idle(2 * HALF);

    cmd1(8'h06);
    spi_begin(); cmd_addr(8'h03, 24'h000000); rd_byte("rd_before_reset", 8'h33);
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(3);
    chk("wel_after_reset", {31'h0, wel}, 0);
    chk("busy_after_reset", {31'h0, busy}, 0);
    chk("miso_after_reset", {31'h0, miso}, 0);
    spi_byte(8'hA5, r);
    chk("miso_sclk_ignored", {24'h0, r}, 0);
    ss_n = 1'b1;
    idle(2 * HALF);
    spi_begin(); send(8'h9F);
    rd_byte("id0_post_reset", 8'hEF); rd_byte("id1_post_reset", 8'h40); rd_byte("id2_post_reset", 8'h16);
    spi_end(); idle(2 * HALF);

    idle(4);
    if (exp_q.size() != 0) begin
      errors += exp_q.size();
      $display("FAIL scoreboard_drain: %0d expectations never answered, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
